// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module     : decode_queue
//  Description: DEPTH-entry {pc, inst} FIFO feeding a registered RV32I decode
//               bundle; serialises control transfers and supports flush.
//  Revision   : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 4,
    parameter int HOLD_CTRL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_ex_unit,
    output logic [4:0]      out_op,
    output logic [XLEN-1:0] out_imm,
    output logic            out_imm_en,
    output logic            out_pc_en,
    output logic [2:0]      out_width,
    output logic [1:0]      out_rs_en,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_en,
    output logic            out_illegal,
    input  logic            flush,
    input  logic            resolve_valid,
    input  logic            resolve_redir,
    output logic            busy_hold
);
    localparam int                c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_depth = (c_ptr_w + 1)'(DEPTH);

    localparam logic [2:0] c_ex_err_unit = 3'd0, c_ex_alu_unit = 3'd1,
                           c_ex_bru_unit = 3'd2, c_ex_lsu_unit = 3'd3;
    localparam logic [4:0] c_alu_nop = 5'd0,  c_alu_add = 5'd1,  c_alu_sub = 5'd2,
                           c_alu_sll = 5'd3,  c_alu_slt = 5'd4,  c_alu_sltu = 5'd5,
                           c_alu_xor = 5'd6,  c_alu_srl = 5'd7,  c_alu_sra = 5'd8,
                           c_alu_or  = 5'd9,  c_alu_and = 5'd10, c_op_jal  = 5'd11,
                           c_op_jalr = 5'd12, c_op_beq  = 5'd13, c_op_bne  = 5'd14,
                           c_op_blt  = 5'd15, c_op_bge  = 5'd16, c_op_bltu = 5'd17,
                           c_op_bgeu = 5'd18, c_op_load = 5'd19, c_op_loadu = 5'd20,
                           c_op_store = 5'd21;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t              r_state;
    logic [XLEN-1:0]     r_pc_mem   [DEPTH];
    logic [31:0]         r_inst_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]    r_count;

    logic w_redir, w_push, w_load, w_is_ctrl;
    logic [31:0]     w_inst;
    logic [2:0]      w_ex, w_width;
    logic [4:0]      w_op, w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_imm;
    logic            w_imm_en, w_pc_en, w_rd_en, w_illegal;
    logic [1:0]      w_rs_en;

    assign in_ready  = rst_n && (r_count < c_depth) && !flush;
    assign busy_hold = (r_state == ST_HOLD);
    assign w_redir   = (r_state == ST_HOLD) && resolve_valid && resolve_redir;
    assign w_push    = in_valid && in_ready && !w_redir;
    assign w_load    = (r_count != '0) && (r_state == ST_RUN) && (!out_valid || out_ready);
    assign w_inst    = r_inst_mem[r_rd_ptr];
    assign w_is_ctrl = (w_ex == c_ex_bru_unit);

    always_comb begin
        w_ex = c_ex_alu_unit;  w_op = c_alu_nop;   w_imm = '0;
        w_imm_en = 1'b0;       w_pc_en = 1'b0;     w_width = 3'd0;
        w_rs_en = 2'b00;       w_rd_en = 1'b0;     w_illegal = 1'b0;
        w_rs1 = w_inst[19:15]; w_rs2 = w_inst[24:20]; w_rd = w_inst[11:7];
        case (w_inst[6:0])
            7'b0010011, 7'b0110011: begin
                w_rd_en  = 1'b1;
                w_imm_en = !w_inst[5];
                w_rs_en  = w_inst[5] ? 2'b11 : 2'b01;
                w_imm    = XLEN'($signed(w_inst[31:20]));
                case (w_inst[14:12])
                    3'b000: w_op = (w_inst[5] && w_inst[30]) ? c_alu_sub : c_alu_add;
                    3'b001: w_op = c_alu_sll;
                    3'b010: w_op = c_alu_slt;
                    3'b011: w_op = c_alu_sltu;
                    3'b100: w_op = c_alu_xor;
                    3'b101: w_op = w_inst[30] ? c_alu_sra : c_alu_srl;
                    3'b110: w_op = c_alu_or;
                    default: w_op = c_alu_and;
                endcase
                // Shift amounts are zero-extended; funct7 must be 0 apart from bit 30
                if (w_inst[13:12] == 2'b01) begin
                    if (!w_inst[5]) w_imm = XLEN'(w_inst[24:20]);
                    if ({w_inst[31], w_inst[29:25]} != 6'd0) w_illegal = 1'b1;
                    if (!w_inst[14] && w_inst[30]) w_illegal = 1'b1;
                end else if (w_inst[5]) begin
                    if ({w_inst[31], w_inst[29:25]} != 6'd0) w_illegal = 1'b1;
                    if (w_inst[30] && w_inst[14:12] != 3'b000) w_illegal = 1'b1;
                end
            end
            7'b0110111, 7'b0010111: begin
                w_op = c_alu_add; w_imm_en = 1'b1; w_rd_en = 1'b1;
                w_pc_en = !w_inst[5];
                w_rs1 = 5'd0;
                w_imm = XLEN'($signed({w_inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                w_ex = c_ex_bru_unit; w_op = c_op_jal; w_imm_en = 1'b1; w_rd_en = 1'b1;
                w_imm = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));
            end
            7'b1100111: begin
                w_ex = c_ex_bru_unit; w_op = c_op_jalr; w_imm_en = 1'b1; w_rd_en = 1'b1;
                w_rs_en = 2'b01;
                w_imm = XLEN'($signed(w_inst[31:20]));
                if (w_inst[14:12] != 3'b000) w_illegal = 1'b1;
            end
            7'b1100011: begin
                w_ex = c_ex_bru_unit; w_rs_en = 2'b11;
                w_imm = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
                case (w_inst[14:12])
                    3'b000: w_op = c_op_beq;
                    3'b001: w_op = c_op_bne;
                    3'b100: w_op = c_op_blt;
                    3'b101: w_op = c_op_bge;
                    3'b110: w_op = c_op_bltu;
                    3'b111: w_op = c_op_bgeu;
                    default: w_illegal = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011: begin
                w_ex = c_ex_lsu_unit; w_imm_en = 1'b1;
                w_width = 3'd1 << w_inst[13:12];
                if (w_inst[13:12] == 2'b11) w_illegal = 1'b1;
                if (w_inst[5]) begin
                    w_op = c_op_store; w_rs_en = 2'b11;
                    w_imm = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
                    if (w_inst[14]) w_illegal = 1'b1;
                end else begin
                    w_op = w_inst[14] ? c_op_loadu : c_op_load;
                    w_rs_en = 2'b01; w_rd_en = 1'b1;
                    w_imm = XLEN'($signed(w_inst[31:20]));
                end
            end
            default: w_illegal = 1'b1;
        endcase
        // An illegal bundle carries nothing but the error marker
        if (w_illegal) begin
            w_ex = c_ex_err_unit; w_op = c_alu_nop; w_imm = '0; w_imm_en = 1'b0;
            w_pc_en = 1'b0; w_width = 3'd0; w_rs_en = 2'b00; w_rd_en = 1'b0;
            w_rs1 = 5'd0; w_rs2 = 5'd0; w_rd = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= in_pc;
            r_inst_mem[r_wr_ptr] <= in_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;   r_wr_ptr <= '0;   r_rd_ptr <= '0;   r_count <= '0;
            out_valid <= 1'b0;   out_pc <= '0;     out_ex_unit <= c_ex_err_unit;
            out_op <= c_alu_nop; out_imm <= '0;    out_imm_en <= 1'b0;
            out_pc_en <= 1'b0;   out_width <= 3'd0; out_rs_en <= 2'b00;
            out_rs1 <= 5'd0;     out_rs2 <= 5'd0;  out_rd <= 5'd0;
            out_rd_en <= 1'b0;   out_illegal <= 1'b0;
        end else if (flush) begin
            r_state <= ST_RUN;   r_wr_ptr <= '0;   r_rd_ptr <= '0;   r_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (w_redir) begin
                r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_load})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
            if (w_load) begin
                out_valid <= 1'b1;   out_pc <= r_pc_mem[r_rd_ptr];
                out_ex_unit <= w_ex; out_op <= w_op;   out_imm <= w_imm;
                out_imm_en <= w_imm_en; out_pc_en <= w_pc_en; out_width <= w_width;
                out_rs_en <= w_rs_en; out_rs1 <= w_rs1; out_rs2 <= w_rs2;
                out_rd <= w_rd;       out_rd_en <= w_rd_en; out_illegal <= w_illegal;
                if (HOLD_CTRL != 0 && w_is_ctrl) r_state <= ST_HOLD;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (r_state == ST_HOLD && resolve_valid) r_state <= ST_RUN;
        end
    end
endmodule
`default_nettype wire
